// File: rtl/pll_reset_sequencer_if.sv
// Interface between the PLL reset sequencer and the logic it gates:
// the PLL lock flag in, and the system reset and loss status out.
interface pll_reset_sequencer_if #(
  parameter int unsigned LOSS_CNT_WIDTH = 8
);
  logic                      locked;
  logic                      sys_reset;
  logic                      ready;
  logic                      lock_lost_pulse;
  logic [LOSS_CNT_WIDTH-1:0] lock_lost_count;

  modport master (
    input  locked,
    output sys_reset,
    output ready,
    output lock_lost_pulse,
    output lock_lost_count
  );

  modport slave (
    output locked,
    input  sys_reset,
    input  ready,
    input  lock_lost_pulse,
    input  lock_lost_count
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Holds sys_reset until the synchronized PLL lock has been stable for
// LOCK_STABLE_CYCLES plus RESET_HOLD_CYCLES; counts lock losses seen in RUN.
module pll_reset_sequencer #(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LOCK_STABLE_CYCLES = 4800,
  parameter int unsigned RESET_HOLD_CYCLES  = 16,
  parameter int unsigned LOSS_CNT_WIDTH     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  pll_reset_sequencer_if.master bus
);

  localparam int unsigned MAX_CYCLES = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                                       LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int unsigned CW = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABILIZE,
    HOLD,
    RUN
  } state_t;

  state_t                    state;
  logic [CW-1:0]             cnt;
  logic [SYNC_STAGES-1:0]    sync;
  logic                      locked_s;
  logic                      sys_reset_r;
  logic                      ready_r;
  logic                      pulse_r;
  logic [LOSS_CNT_WIDTH-1:0] loss_cnt;

  assign locked_s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], bus.locked};
    end
  end

  // Outputs are assigned alongside each transition so they reflect the
  // next state on the same edge without a separate next-state decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WAIT_LOCK;
      cnt         <= '0;
      sys_reset_r <= 1'b1;
      ready_r     <= 1'b0;
      pulse_r     <= 1'b0;
      loss_cnt    <= '0;
    end else begin
      sys_reset_r <= 1'b1;
      ready_r     <= 1'b0;
      pulse_r     <= 1'b0;
      unique case (state)
        WAIT_LOCK: begin
          cnt <= '0;
          if (locked_s) begin
            state <= STABILIZE;
          end
        end
        STABILIZE: begin
          if (!locked_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state <= HOLD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (!locked_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == HOLD_LAST) begin
            state       <= RUN;
            cnt         <= '0;
            sys_reset_r <= 1'b0;
            ready_r     <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            pulse_r <= 1'b1;
            if (loss_cnt != '1) begin
              loss_cnt <= loss_cnt + 1'b1;
            end
          end else begin
            sys_reset_r <= 1'b0;
            ready_r     <= 1'b1;
          end
        end
        default: begin
          state <= WAIT_LOCK;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.sys_reset       = sys_reset_r;
  assign bus.ready           = ready_r;
  assign bus.lock_lost_pulse = pulse_r;
  assign bus.lock_lost_count = loss_cnt;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench: the stimulus process predicts each edge's outputs from
// the lock run-length rule; a negedge monitor pops and compares.
module tb_pll_reset_sequencer;

  localparam int unsigned SYNC_STAGES        = 2;
  localparam int unsigned LOCK_STABLE_CYCLES = 8;
  localparam int unsigned RESET_HOLD_CYCLES  = 4;
  localparam int unsigned LOSS_CNT_WIDTH     = 2;
  // Consecutive sampled-locked edges needed before RUN.
  localparam int unsigned RUN_LEN = 1 + LOCK_STABLE_CYCLES + RESET_HOLD_CYCLES;
  localparam int unsigned CNT_MAX = (1 << LOSS_CNT_WIDTH) - 1;

  typedef struct packed {
    logic                      sys_reset;
    logic                      ready;
    logic                      pulse;
    logic [LOSS_CNT_WIDTH-1:0] count;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb[$];
  int   checks;
  int   errors;
  int   pulses_seen;

  // Reference state
  bit   hist[$];
  int   run_len;
  int   loss_count;

  pll_reset_sequencer_if #(.LOSS_CNT_WIDTH(LOSS_CNT_WIDTH)) bus ();

  pll_reset_sequencer #(
    .SYNC_STAGES       (SYNC_STAGES),
    .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES),
    .RESET_HOLD_CYCLES (RESET_HOLD_CYCLES),
    .LOSS_CNT_WIDTH    (LOSS_CNT_WIDTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Predict outputs after an edge on which the DUT saw (r, l).
  task automatic model_edge(input bit r, input bit l);
    exp_t e;
    bit   ls;
    bit   was_run;
    if (r) begin
      hist.delete();
      for (int i = 0; i < int'(SYNC_STAGES); i++) hist.push_back(1'b0);
      run_len    = 0;
      loss_count = 0;
      e = '{sys_reset: 1'b1, ready: 1'b0, pulse: 1'b0, count: '0};
    end else begin
      ls = hist.pop_front();
      hist.push_back(l);
      was_run = (run_len >= int'(RUN_LEN));
      if (ls) run_len = (run_len < int'(RUN_LEN)) ? run_len + 1 : run_len;
      else    run_len = 0;
      e.pulse = !ls && was_run;
      if (e.pulse && loss_count < int'(CNT_MAX)) loss_count++;
      e.ready     = (run_len >= int'(RUN_LEN));
      e.sys_reset = !e.ready;
      e.count     = LOSS_CNT_WIDTH'(loss_count);
    end
    sb.push_back(e);
  endtask

  task automatic drive(input bit r, input bit l, input int n);
    for (int i = 0; i < n; i++) begin
      reset      = r;
      bus.locked = l;
      @(posedge clk);
      model_edge(r, l);
      #1;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sys_reset",       8'(bus.sys_reset),       8'(e.sys_reset));
        chk("ready",           8'(bus.ready),           8'(e.ready));
        chk("lock_lost_pulse", 8'(bus.lock_lost_pulse), 8'(e.pulse));
        chk("lock_lost_count", 8'(bus.lock_lost_count), 8'(e.count));
        if (bus.lock_lost_pulse === 1'b1) pulses_seen++;
      end
    end
  end

  initial begin : stimulus
    int unsigned seg;
    checks      = 0;
    errors      = 0;
    pulses_seen = 0;
    run_len     = 0;
    loss_count  = 0;
    for (int i = 0; i < int'(SYNC_STAGES); i++) hist.push_back(1'b0);
    reset      = 1'b1;
    bus.locked = 1'b1;

    // Clean power-up: release expected at edge 15 after reset drops.
    drive(1'b1, 1'b1, 3);
    drive(1'b0, 1'b1, 20);
    // Glitch in STABILIZE (entered at edge 3, glitch from edge 7).
    drive(1'b1, 1'b1, 1);
    drive(1'b0, 1'b1, 7);
    drive(1'b0, 1'b0, 3);
    drive(1'b0, 1'b1, 25);
    // Loss in RUN.
    drive(1'b0, 1'b0, 10);
    drive(1'b0, 1'b1, 20);
    // Saturation: count walks past 3.
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, 3);
      drive(1'b0, 1'b1, 18);
    end
    // Reset while in RUN.
    drive(1'b1, 1'b1, 1);
    drive(1'b0, 1'b1, 20);
    // Reset two cycles into HOLD (HOLD entered at edge 11).
    drive(1'b1, 1'b1, 1);
    drive(1'b0, 1'b1, 13);
    drive(1'b1, 1'b1, 1);
    drive(1'b0, 1'b1, 20);

    // Randomized segments of lock/loss with occasional resets.
    for (int s = 0; s < 250; s++) begin
      seg = $urandom_range(1, 20);
      if ($urandom_range(0, 15) == 0) drive(1'b1, 1'($urandom), 1);
      drive(1'b0, 1'($urandom_range(0, 3) != 0), int'(seg));
    end
    drive(1'b0, 1'b1, 16);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 8'(sb.size()), 8'd0);
    chk("pulses_observed", 8'(pulses_seen != 0), 8'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Sits directly downstream of the ECP5 system PLL, in the 48 MHz output clock domain. Takes the PLL's asynchronous `locked` flag and produces the design-wide active-high `sys_reset`. `sys_reset` releases only after lock has been continuously stable for a programmable interval, followed by a fixed hold. It also counts and flags lock-loss events seen during normal operation.

## Interface
- `SYNC_STAGES`, 2: depth of the `locked` synchronizer chain; legal ≥ 2.
- `LOCK_STABLE_CYCLES`, 4800: consecutive synchronized-locked cycles required, 100 µs at 48 MHz; legal ≥ 1.
- `RESET_HOLD_CYCLES`, 16: extra cycles `sys_reset` stays high after the stability interval; legal ≥ 1.
- `LOSS_CNT_WIDTH`, 8: width of the lock-loss counter.

Ports:
- `clk` in 1: PLL output clock (clkout0, 48 MHz); the single clock.
- `reset` in 1: synchronous, active-high; has priority over all other behaviour.
- `locked` in 1: PLL lock flag, asynchronous to `clk`.
- `sys_reset` out 1: active-high system reset, registered.
- `ready` out 1: high exactly when `sys_reset` is low, registered.
- `lock_lost_pulse` out 1: one-cycle strobe on each lock loss in RUN.
- `lock_lost_count` out `LOSS_CNT_WIDTH`: saturating count of lock losses in RUN.

## Operation
- Synchronizer: `SYNC_STAGES` flops in series; `locked_s` is the last stage. All stages clear to 0 on `reset`.
- Stage counter: one counter, width = clog2(max(`LOCK_STABLE_CYCLES`, `RESET_HOLD_CYCLES`)) + 1.
- FSM states are WAIT_LOCK, STABILIZE, HOLD and RUN.
  - WAIT_LOCK: counter is 0. If `locked_s` = 1, go to STABILIZE.
  - STABILIZE: if `locked_s` = 0, go to WAIT_LOCK with no loss recorded. Else, if counter = `LOCK_STABLE_CYCLES`−1, go to HOLD and clear the counter. Else increment the counter.
  - HOLD: if `locked_s` = 0, go to WAIT_LOCK with no loss recorded. Else, if counter = `RESET_HOLD_CYCLES`−1, go to RUN. Else increment the counter.
  - RUN: if `locked_s` = 0, go to WAIT_LOCK, pulse `lock_lost_pulse`, and increment `lock_lost_count` (saturating at 2^`LOSS_CNT_WIDTH`−1). Else stay in RUN.
- Registered outputs:
  - `sys_reset` <= (next_state != RUN).
  - `ready` <= (next_state == RUN).
  - `lock_lost_pulse` <= RUN→WAIT_LOCK transition this edge.
- `lock_lost_count` is cleared only by `reset`. It holds its value through re-lock.
- Counter wraps are impossible: every increment is bounded by a terminal compare.

## Timing
- Reset values, on any edge with `reset` = 1:
  - state WAIT_LOCK, counter 0, synchronizer all 0.
  - `sys_reset` = 1, `ready` = 0, `lock_lost_pulse` = 0, `lock_lost_count` = 0.
- `reset` asserted mid-operation overrides: outputs take reset values on that edge, including while in RUN. No loss is counted and no pulse is generated.
- Release latency: take `locked` stable high before edge 1 after reset deasserts.
  - `locked_s` is high after edge `SYNC_STAGES`.
  - STABILIZE is entered at edge `SYNC_STAGES`+1.
  - `sys_reset` falls and `ready` rises at edge `SYNC_STAGES`+1+`LOCK_STABLE_CYCLES`+`RESET_HOLD_CYCLES`.
- Loss latency: `locked` falls before edge k. `sys_reset` rises, `ready` falls, and `lock_lost_pulse` goes high at edge k+`SYNC_STAGES`. The pulse lasts exactly one cycle.
- A dropout shorter than one `clk` period may be missed by the synchronizer; that is acceptable.
- A dropout that reaches `locked_s` in STABILIZE or HOLD restarts the full sequence from WAIT_LOCK.
- After a loss, re-lock repeats the full release latency measured from the new rising edge of `locked`.

## Test plan
Bench parameters for all scenarios: `SYNC_STAGES`=2, `LOCK_STABLE_CYCLES`=8, `RESET_HOLD_CYCLES`=4, `LOSS_CNT_WIDTH`=2.

- **Clean power-up:** `reset` high for 3 cycles, `locked` high from the start -> `sys_reset` = 1 through edge 14 after reset release and falls at edge 15; `ready` rises at edge 15; count stays 0; pulse never asserts.
- **Glitch during STABILIZE:** `locked` low for 3 cycles starting 4 cycles after STABILIZE entry -> `sys_reset` stays high; count stays 0; the 15-edge release restarts from the next `locked` rising edge.
- **Loss in RUN:** from RUN, drop `locked` for 10 cycles -> 2 edges later `sys_reset` = 1, `ready` = 0, `lock_lost_pulse` high for exactly 1 cycle, count = 1; after `locked` returns, `sys_reset` falls 15 edges after the rise.
- **Counter saturation:** 5 loss/re-lock cycles in RUN -> count reads 1, 2, 3, 3, 3; a pulse occurs on every loss.
- **Reset mid-operation:** assert `reset` for 1 cycle while in RUN -> next edge gives `sys_reset` = 1, count = 0, no pulse; the full release latency is repeated.
- **Reset during HOLD:** assert `reset` 2 cycles into HOLD -> `sys_reset` is never released early; release occurs 15 edges after `reset` deasserts.
